// File: rtl/reorder_buffer_mc.sv
// In-order ROB: allocates at tail, accepts WB_PORTS writebacks and retires up to COMMIT entries per cycle.
// A writeback in cycle M commits in M+2 at the earliest; rob_busy stalls decode when all entries are in use.
module reorder_buffer_mc #(
  parameter int DATA      = 32,
  parameter int ADDR      = 32,
  parameter int REG       = 5,
  parameter int EXP       = 4,
  parameter int ROB_DEPTH = 16,
  parameter int ROB       = $clog2(ROB_DEPTH),
  parameter int WB_PORTS  = 2,
  parameter int COMMIT    = 2
) (
  input  logic                     clk,
  input  logic                     reset_,
  input  logic [ADDR-1:0]          creg_tvec,
  input  logic                     dec_e_,
  input  logic [ADDR-1:0]          dec_pc,
  input  logic [REG-1:0]           dec_rd,
  input  logic                     dec_rd_we,
  output logic [ROB-1:0]           dec_rob_id,
  output logic                     rob_busy,
  output logic                     rob_empty,
  input  logic [WB_PORTS-1:0]      wb_e_,
  input  logic [WB_PORTS*ROB-1:0]  wb_rob_id,
  input  logic [WB_PORTS*DATA-1:0] wb_data,
  input  logic [WB_PORTS-1:0]      wb_exp_,
  input  logic [WB_PORTS*EXP-1:0]  wb_exp_code,
  input  logic [WB_PORTS-1:0]      wb_miss_,
  input  logic [WB_PORTS*ADDR-1:0] wb_target,
  output logic [COMMIT-1:0]        commit_e_,
  output logic [COMMIT*ROB-1:0]    commit_rob_id,
  output logic [COMMIT*ADDR-1:0]   commit_pc,
  output logic [COMMIT*REG-1:0]    commit_rd,
  output logic [COMMIT-1:0]        commit_we,
  output logic [COMMIT*DATA-1:0]   commit_data,
  output logic                     commit_exp_,
  output logic [EXP-1:0]           commit_exp_code,
  output logic                     flush_,
  output logic [ADDR-1:0]          flush_pc
);

  logic [ROB:0]           head_q, head_d, tail_q, tail_d, count, n_commit;
  logic [ROB_DEPTH-1:0]   valid_q, valid_d, done_q, we_q, exp_q, miss_q;
  logic [ADDR-1:0]        pc_q   [ROB_DEPTH];
  logic [REG-1:0]         rd_q   [ROB_DEPTH];
  logic [DATA-1:0]        data_q [ROB_DEPTH];
  logic [EXP-1:0]         code_q [ROB_DEPTH];
  logic [ADDR-1:0]        tgt_q  [ROB_DEPTH];
  logic                   alloc, stop;
  logic [ROB-1:0]         idx;

  logic [COMMIT-1:0]      commit_e_q, commit_e_d, commit_we_q, commit_we_d;
  logic [COMMIT*ROB-1:0]  commit_rob_id_q, commit_rob_id_d;
  logic [COMMIT*ADDR-1:0] commit_pc_q, commit_pc_d;
  logic [COMMIT*REG-1:0]  commit_rd_q, commit_rd_d;
  logic [COMMIT*DATA-1:0] commit_data_q, commit_data_d;
  logic                   commit_exp_q, commit_exp_d, flush_q, flush_d;
  logic [EXP-1:0]         commit_exp_code_q, commit_exp_code_d;
  logic [ADDR-1:0]        flush_pc_q, flush_pc_d;

  assign count      = tail_q - head_q;
  assign rob_empty  = (head_q == tail_q);
  assign rob_busy   = (count == (ROB+1)'(ROB_DEPTH));
  assign dec_rob_id = tail_q[ROB-1:0];
  // Allocation is dropped while the flush pulse is out: the younger stream is being discarded.
  assign alloc      = !dec_e_ && !rob_busy && flush_q;

  always_comb begin
    commit_e_d        = '1;
    commit_we_d       = '0;
    commit_rob_id_d   = '0;
    commit_pc_d       = '0;
    commit_rd_d       = '0;
    commit_data_d     = '0;
    commit_exp_d      = 1'b1;
    commit_exp_code_d = '0;
    flush_d           = 1'b1;
    flush_pc_d        = '0;
    n_commit          = '0;
    stop              = 1'b0;
    idx               = '0;
    valid_d           = valid_q;
    if (alloc) valid_d[tail_q[ROB-1:0]] = 1'b1;
    for (int k = 0; k < COMMIT; k++) begin
      idx = head_q[ROB-1:0] + ROB'(k);
      if (!stop && valid_q[idx] && done_q[idx]) begin
        commit_e_d[k]                  = 1'b0;
        commit_rob_id_d[k*ROB +: ROB]  = idx;
        commit_pc_d[k*ADDR +: ADDR]    = pc_q[idx];
        commit_rd_d[k*REG +: REG]      = rd_q[idx];
        commit_data_d[k*DATA +: DATA]  = data_q[idx];
        commit_we_d[k]                 = we_q[idx] && !exp_q[idx];
        valid_d[idx]                   = 1'b0;
        n_commit                       = (ROB+1)'(k + 1);
        if (exp_q[idx]) begin
          commit_exp_d      = 1'b0;
          commit_exp_code_d = code_q[idx];
          flush_d           = 1'b0;
          flush_pc_d        = creg_tvec;
          stop              = 1'b1;
        end else if (miss_q[idx]) begin
          flush_d    = 1'b0;
          flush_pc_d = tgt_q[idx];
          stop       = 1'b1;
        end
      end else begin
        stop = 1'b1;
      end
    end
    head_d = head_q + n_commit;
    tail_d = tail_q + {{ROB{1'b0}}, alloc};
    if (!flush_d) begin
      valid_d = '0;
      head_d  = '0;
      tail_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      head_q            <= '0;
      tail_q            <= '0;
      valid_q           <= '0;
      commit_e_q        <= '1;
      commit_we_q       <= '0;
      commit_rob_id_q   <= '0;
      commit_pc_q       <= '0;
      commit_rd_q       <= '0;
      commit_data_q     <= '0;
      commit_exp_q      <= 1'b1;
      commit_exp_code_q <= '0;
      flush_q           <= 1'b1;
      flush_pc_q        <= '0;
    end else begin
      head_q            <= head_d;
      tail_q            <= tail_d;
      valid_q           <= valid_d;
      commit_e_q        <= commit_e_d;
      commit_we_q       <= commit_we_d;
      commit_rob_id_q   <= commit_rob_id_d;
      commit_pc_q       <= commit_pc_d;
      commit_rd_q       <= commit_rd_d;
      commit_data_q     <= commit_data_d;
      commit_exp_q      <= commit_exp_d;
      commit_exp_code_q <= commit_exp_code_d;
      flush_q           <= flush_d;
      flush_pc_q        <= flush_pc_d;
    end
  end

  // Payload is qualified by valid_q, so it needs no reset. Ports are scanned high to low so port 0 wins a clash.
  always_ff @(posedge clk) begin
    if (alloc) begin
      pc_q[tail_q[ROB-1:0]]   <= dec_pc;
      rd_q[tail_q[ROB-1:0]]   <= dec_rd;
      we_q[tail_q[ROB-1:0]]   <= dec_rd_we;
      done_q[tail_q[ROB-1:0]] <= 1'b0;
    end
    for (int p = WB_PORTS - 1; p >= 0; p--) begin
      if (!wb_e_[p] && valid_q[wb_rob_id[p*ROB +: ROB]]) begin
        done_q[wb_rob_id[p*ROB +: ROB]] <= 1'b1;
        data_q[wb_rob_id[p*ROB +: ROB]] <= wb_data[p*DATA +: DATA];
        exp_q[wb_rob_id[p*ROB +: ROB]]  <= !wb_exp_[p];
        code_q[wb_rob_id[p*ROB +: ROB]] <= wb_exp_code[p*EXP +: EXP];
        miss_q[wb_rob_id[p*ROB +: ROB]] <= !wb_miss_[p];
        tgt_q[wb_rob_id[p*ROB +: ROB]]  <= wb_target[p*ADDR +: ADDR];
      end
    end
  end

  assign commit_e_       = commit_e_q;
  assign commit_we       = commit_we_q;
  assign commit_rob_id   = commit_rob_id_q;
  assign commit_pc       = commit_pc_q;
  assign commit_rd       = commit_rd_q;
  assign commit_data     = commit_data_q;
  assign commit_exp_     = commit_exp_q;
  assign commit_exp_code = commit_exp_code_q;
  assign flush_          = flush_q;
  assign flush_pc        = flush_pc_q;

endmodule

// File: tb/tb_reorder_buffer_mc.sv
// Scoreboard bench for reorder_buffer_mc at default parameters.
module tb_reorder_buffer_mc;
  localparam int DATA = 32, ADDR = 32, REG = 5, EXP = 4, ROB_DEPTH = 16, ROB = 4, WB_PORTS = 2, COMMIT = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                     reset_;
  logic [ADDR-1:0]          creg_tvec;
  logic                     dec_e_;
  logic [ADDR-1:0]          dec_pc;
  logic [REG-1:0]           dec_rd;
  logic                     dec_rd_we;
  logic [ROB-1:0]           dec_rob_id;
  logic                     rob_busy, rob_empty;
  logic [WB_PORTS-1:0]      wb_e_, wb_exp_, wb_miss_;
  logic [WB_PORTS*ROB-1:0]  wb_rob_id;
  logic [WB_PORTS*DATA-1:0] wb_data;
  logic [WB_PORTS*EXP-1:0]  wb_exp_code;
  logic [WB_PORTS*ADDR-1:0] wb_target;
  logic [COMMIT-1:0]        commit_e_, commit_we;
  logic [COMMIT*ROB-1:0]    commit_rob_id;
  logic [COMMIT*ADDR-1:0]   commit_pc;
  logic [COMMIT*REG-1:0]    commit_rd;
  logic [COMMIT*DATA-1:0]   commit_data;
  logic                     commit_exp_, flush_;
  logic [EXP-1:0]           commit_exp_code;
  logic [ADDR-1:0]          flush_pc;

  reorder_buffer_mc dut (
    .clk(clk), .reset_(reset_), .creg_tvec(creg_tvec),
    .dec_e_(dec_e_), .dec_pc(dec_pc), .dec_rd(dec_rd), .dec_rd_we(dec_rd_we),
    .dec_rob_id(dec_rob_id), .rob_busy(rob_busy), .rob_empty(rob_empty),
    .wb_e_(wb_e_), .wb_rob_id(wb_rob_id), .wb_data(wb_data), .wb_exp_(wb_exp_),
    .wb_exp_code(wb_exp_code), .wb_miss_(wb_miss_), .wb_target(wb_target),
    .commit_e_(commit_e_), .commit_rob_id(commit_rob_id), .commit_pc(commit_pc),
    .commit_rd(commit_rd), .commit_we(commit_we), .commit_data(commit_data),
    .commit_exp_(commit_exp_), .commit_exp_code(commit_exp_code),
    .flush_(flush_), .flush_pc(flush_pc)
  );

  int n_vec = 0;
  int n_err = 0;
  int n_commits = 0;

  // Reference model: per-id payload plus the program-order queue of ids awaiting commit.
  logic [ADDR-1:0] m_pc   [ROB_DEPTH];
  logic [REG-1:0]  m_rd   [ROB_DEPTH];
  logic            m_we   [ROB_DEPTH];
  logic [DATA-1:0] m_data [ROB_DEPTH];
  logic            m_exp  [ROB_DEPTH];
  logic [EXP-1:0]  m_code [ROB_DEPTH];
  logic            m_miss [ROB_DEPTH];
  logic [ADDR-1:0] m_tgt  [ROB_DEPTH];
  logic [ROB-1:0]  m_tail = '0;
  int              sb[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    dec_e_   = 1'b1;
    wb_e_    = '1;
    wb_exp_  = '1;
    wb_miss_ = '1;
  endtask

  task automatic alloc(input logic [ADDR-1:0] pc, input logic [REG-1:0] rd, input logic we, input bit accept);
    dec_e_ = 1'b0; dec_pc = pc; dec_rd = rd; dec_rd_we = we;
    if (accept) begin
      chk("dec_rob_id", dec_rob_id, m_tail);
      m_pc[m_tail] = pc; m_rd[m_tail] = rd; m_we[m_tail] = we;
      m_exp[m_tail] = 1'b0; m_miss[m_tail] = 1'b0;
      sb.push_back(int'(m_tail));
      m_tail++;
    end
    tick();
  endtask

  task automatic set_wb(input int p, input logic [ROB-1:0] id, input logic [DATA-1:0] d,
                        input logic expf, input logic [EXP-1:0] code, input logic missf, input logic [ADDR-1:0] tgt);
    wb_e_[p] = 1'b0;
    wb_rob_id[p*ROB +: ROB]    = id;
    wb_data[p*DATA +: DATA]    = d;
    wb_exp_[p]                 = !expf;
    wb_exp_code[p*EXP +: EXP]  = code;
    wb_miss_[p]                = !missf;
    wb_target[p*ADDR +: ADDR]  = tgt;
    m_data[id] = d; m_exp[id] = expf; m_code[id] = code; m_miss[id] = missf; m_tgt[id] = tgt;
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && sb.size() != 0; i++) tick();
    chk("drain_empty", sb.size(), 0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    reset_ = 1'b0;
    sb.delete();
    m_tail = '0;
    #10;
    @(posedge clk);
    #1;
    reset_ = 1'b1;
  endtask

  int             mon_id;
  bit             mon_fl, mon_fexp, mon_prev_idle;
  logic [ADDR-1:0] mon_fpc;
  logic [EXP-1:0]  mon_fcode;

  always @(negedge clk) begin
    if (reset_) begin
      mon_fl = 1'b0; mon_fexp = 1'b0; mon_fpc = '0; mon_fcode = '0; mon_prev_idle = 1'b0;
      for (int k = 0; k < COMMIT; k++) begin
        if (mon_prev_idle) chk("commit_contig", commit_e_[k], 1);
        else if (mon_fl) chk("commit_after_flush", commit_e_[k], 1);
        else if (!commit_e_[k]) begin
          n_commits++;
          if (sb.size() == 0) chk("sb_underflow", sb.size(), 1);
          else begin
            mon_id = sb.pop_front();
            chk("commit_rob_id", commit_rob_id[k*ROB +: ROB], mon_id);
            chk("commit_pc", commit_pc[k*ADDR +: ADDR], m_pc[mon_id]);
            chk("commit_rd", commit_rd[k*REG +: REG], m_rd[mon_id]);
            chk("commit_data", commit_data[k*DATA +: DATA], m_data[mon_id]);
            chk("commit_we", commit_we[k], m_we[mon_id] && !m_exp[mon_id]);
            if (m_exp[mon_id] || m_miss[mon_id]) begin
              mon_fl    = 1'b1;
              mon_fexp  = m_exp[mon_id];
              mon_fcode = m_code[mon_id];
              mon_fpc   = m_exp[mon_id] ? creg_tvec : m_tgt[mon_id];
            end
          end
        end
        mon_prev_idle = commit_e_[k];
      end
      chk("flush_", flush_, !mon_fl);
      if (mon_fl) chk("flush_pc", flush_pc, mon_fpc);
      chk("commit_exp_", commit_exp_, !mon_fexp);
      chk("commit_exp_code", commit_exp_code, mon_fexp ? mon_fcode : '0);
      if (mon_fl) begin
        sb.delete();
        m_tail = '0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  logic [ROB-1:0] ids [8];
  logic [ROB-1:0] tmp;
  int             c0, r;

  initial begin
    reset_ = 1'b0; creg_tvec = '0;
    dec_e_ = 1'b1; dec_pc = '0; dec_rd = '0; dec_rd_we = 1'b0;
    wb_e_ = '1; wb_rob_id = '0; wb_data = '0; wb_exp_ = '1; wb_exp_code = '0; wb_miss_ = '1; wb_target = '0;
    #23;
    chk("rst_commit_e_", commit_e_, 2'b11);
    chk("rst_flush_", flush_, 1);
    chk("rst_commit_pc", commit_pc, 0);
    chk("rst_rob_empty", rob_empty, 1);
    chk("rst_rob_busy", rob_busy, 0);
    chk("rst_dec_rob_id", dec_rob_id, 0);
    @(posedge clk); #1; reset_ = 1'b1;

    // Single entry: latency M -> M+2
    alloc(32'h1000, 5'd1, 1'b1, 1);
    set_wb(0, 4'd0, 32'haaaa, 0, 0, 0, 0);
    tick();
    @(negedge clk); chk("t1_commit_e_M1", commit_e_, 2'b11);
    @(negedge clk); chk("t1_commit_e_M2", commit_e_, 2'b10);
    chk("t1_rob_empty", rob_empty, 1);
    @(posedge clk); #1;

    // Same id on both ports: port 0 wins
    alloc(32'h1100, 5'd4, 1'b1, 1);
    set_wb(1, 4'd1, 32'h222, 0, 0, 0, 0);
    set_wb(0, 4'd1, 32'h111, 0, 0, 0, 0);
    tick();
    drain();

    // Eight entries, written back out of order two per cycle
    c0 = n_commits;
    for (int i = 0; i < 8; i++) begin
      ids[i] = m_tail;
      alloc(32'h2000 + 32'(4 * i), 5'(i + 2), 1'b1, 1);
    end
    for (int i = 7; i > 0; i--) begin
      r = $urandom_range(i, 0);
      tmp = ids[i]; ids[i] = ids[r]; ids[r] = tmp;
    end
    for (int j = 0; j < 4; j++) begin
      set_wb(0, ids[2*j],   32'h5000 + 32'(ids[2*j]),   0, 0, 0, 0);
      set_wb(1, ids[2*j+1], 32'h5000 + 32'(ids[2*j+1]), 0, 0, 0, 0);
      tick();
    end
    drain();
    chk("t2_commit_count", n_commits - c0, 8);

    // Full buffer, stall, wrap
    do_reset();
    for (int i = 0; i < 16; i++) alloc(32'h4000 + 32'(4 * i), 5'(i), 1'(i % 2), 1);
    chk("t3_busy_full", rob_busy, 1);
    chk("t3_not_empty", rob_empty, 0);
    alloc(32'h4100, 5'd9, 1'b1, 0);
    chk("t3_busy_after_drop", rob_busy, 1);
    set_wb(0, 4'd0, 32'h9000, 0, 0, 0, 0);
    tick();
    @(negedge clk); chk("t3_busy_M1", rob_busy, 1);
    @(negedge clk); chk("t3_busy_M2", rob_busy, 0);
    @(posedge clk); #1;
    chk("t3_wrap_id", dec_rob_id, 0);
    alloc(32'h4200, 5'd7, 1'b1, 1);
    for (int j = 0; j < 8; j++) begin
      set_wb(0, 4'(2*j + 1), 32'h9100 + 32'(j), 0, 0, 0, 0);
      set_wb(1, 4'(2*j + 2), 32'h9200 + 32'(j), 0, 0, 0, 0);
      tick();
    end
    drain();

    // Mispredict on entry 1
    do_reset();
    alloc(32'h5000, 5'd1, 1'b1, 1);
    alloc(32'h5004, 5'd2, 1'b1, 1);
    alloc(32'h5008, 5'd3, 1'b1, 1);
    set_wb(0, 4'd2, 32'hc2, 0, 0, 0, 0);
    tick();
    set_wb(0, 4'd0, 32'hc0, 0, 0, 0, 0);
    set_wb(1, 4'd1, 32'hc1, 0, 0, 1, 32'h3000);
    tick();
    @(negedge clk);
    @(negedge clk);
    chk("t4_commit_e_", commit_e_, 2'b00);
    chk("t4_flush_", flush_, 0);
    chk("t4_flush_pc", flush_pc, 32'h3000);
    chk("t4_empty_in_flush", rob_empty, 1);
    chk("t4_busy_in_flush", rob_busy, 0);
    @(posedge clk); #1;
    chk("t4_dec_rob_id", dec_rob_id, 0);
    repeat (3) tick();
    chk("t4_empty_after", rob_empty, 1);

    // Exception on entry 0 with a dropped same-cycle allocation
    do_reset();
    creg_tvec = 32'hcafe0000;
    alloc(32'h6000, 5'd3, 1'b1, 1);
    set_wb(0, 4'd0, 32'h77, 1, 4'd2, 0, 0);
    tick();
    @(posedge clk); #1;
    chk("t5_flush_cycle", flush_, 0);
    alloc(32'h6004, 5'd4, 1'b1, 0);
    chk("t5_empty_after_drop", rob_empty, 1);
    chk("t5_dec_rob_id", dec_rob_id, 0);

    // Asynchronous reset mid-clock with entries pending
    for (int i = 0; i < 5; i++) alloc(32'h7000 + 32'(4 * i), 5'(i + 1), 1'b1, 1);
    set_wb(0, 4'd0, 32'h70, 0, 0, 0, 0);
    set_wb(1, 4'd1, 32'h71, 0, 0, 0, 0);
    tick();
    @(posedge clk); #2;
    chk("t6_commit_before_rst", commit_e_, 2'b00);
    reset_ = 1'b0;
    sb.delete();
    m_tail = '0;
    #1;
    chk("t6_rst_commit_e_", commit_e_, 2'b11);
    chk("t6_rst_commit_pc", commit_pc, 0);
    chk("t6_rst_commit_we", commit_we, 0);
    chk("t6_rst_flush_", flush_, 1);
    chk("t6_rst_empty", rob_empty, 1);
    chk("t6_rst_busy", rob_busy, 0);
    chk("t6_rst_dec_rob_id", dec_rob_id, 0);
    @(posedge clk); #1; reset_ = 1'b1;
    tick();
    chk("t6_post_dec_rob_id", dec_rob_id, 0);
    chk("t6_post_empty", rob_empty, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/reorder_buffer_mc.md
Name: reorder_buffer_mc

Overview:
Parametrised successor of the single-port reorder buffer. It tracks in-flight instructions in program order and accepts writebacks on WB_PORTS parallel ports. It retires up to COMMIT instructions per cycle in order. On the oldest exception or branch/jump mispredict it raises a one-cycle flush with the redirect PC. It sits between decode/rename, which allocates entries, the execution writeback buses, and the architectural register file / rename table, which consume commits.

Parameters:
DATA, 32, writeback data width
ADDR, 32, PC width
REG, 5, architectural register address width
EXP, 4, exception code width
ROB_DEPTH, 16, number of entries; power of two, at least 4
ROB, $clog2(ROB_DEPTH), entry id width (derived)
WB_PORTS, 2, number of writeback ports, 1..4
COMMIT, 2, maximum retirements per cycle, 1..4, not greater than ROB_DEPTH

Ports:
clk  in  1  clock
reset_  in  1  reset, asynchronous, active-low
creg_tvec  in  ADDR  exception handler PC
dec_e_  in  1  allocate request (low = valid)
dec_pc  in  ADDR  PC of allocating instruction
dec_rd  in  REG  destination architectural register
dec_rd_we  in  1  instruction writes dec_rd
dec_rob_id  out  ROB  id assigned to the current allocation (= tail)
rob_busy  out  1  ROB full; decode must stall
rob_empty  out  1  no valid entries
wb_e_  in  WB_PORTS  per-port writeback valid (low)
wb_rob_id  in  WB_PORTS*ROB  target entry per port
wb_data  in  WB_PORTS*DATA  result per port
wb_exp_  in  WB_PORTS  exception flag (low)
wb_exp_code  in  WB_PORTS*EXP  exception code
wb_miss_  in  WB_PORTS  branch/jump mispredict (low)
wb_target  in  WB_PORTS*ADDR  correct target when mispredicted
commit_e_  out  COMMIT  per-slot commit valid (low); contiguous from slot 0
commit_rob_id  out  COMMIT*ROB  committed entry id per slot
commit_pc  out  COMMIT*ADDR  committed PC per slot
commit_rd  out  COMMIT*REG  destination per slot
commit_we  out  COMMIT  register write enable per slot
commit_data  out  COMMIT*DATA  result per slot
commit_exp_  out  1  an exception is committed this cycle (low)
commit_exp_code  out  EXP  code of that exception
flush_  out  1  pipeline flush pulse (low)
flush_pc  out  ADDR  redirect PC

Behaviour:
- State: head and tail pointers of ROB+1 bits, with the MSB as the wrap bit. Each entry holds valid, done, pc, rd, we, data, exp, code, miss, target.
- rob_empty = (head == tail). rob_busy = (count == ROB_DEPTH), computed from registered state only. A commit in the same cycle does not release the stall.
- Allocation: if dec_e_ low and rob_busy low, write the entry at tail (valid=1, done=0) and increment tail, wrapping modulo 2*ROB_DEPTH. dec_rob_id = tail[ROB-1:0], combinational.
- dec_e_ low while rob_busy high is ignored. dec_e_ low during a cycle in which flush_ is low is also ignored.
- Writeback: for each port with wb_e_ low and a valid target entry, set done and store data/exp/code/miss/target at the clock edge.
- A writeback to an invalid entry is ignored.
- Two ports targeting the same id in one cycle is illegal; the lowest-index port wins.
- Commit selection is combinational from registered state; all commit_*/flush outputs are registered.
- Slot k (0..COMMIT-1) commits the entry at head+k if entries head..head+k are all valid and done, and none of head..head+k-1 has exp or miss. Selection stops after the first entry with exp or miss.
- Head advances by the number of slots committed at the same edge the outputs register.
- Latency: writeback in cycle M makes the entry done at the end of M. Its commit outputs are valid during cycle M+2 at the earliest. All outputs are single-cycle pulses.
- Exception entry commits: commit_exp_ low, commit_exp_code = code, commit_we = 0 for that slot, flush_ low, flush_pc = creg_tvec. Older slots in the same cycle commit normally.
- Mispredict entry commits: the result is written (commit_we = we), flush_ low, flush_pc = target.
- Flush: at the edge that registers flush_, all entries are invalidated and head = tail = 0. During the flush_ cycle rob_empty = 1 and rob_busy = 0.
- Exception and miss on the same entry: the exception takes priority (flush_pc = creg_tvec).
- Idle/inactive output values: commit_e_ all 1, commit_exp_ 1, flush_ 1; pc/rd/data/code/flush_pc 0; commit_we 0.
- Reset (asynchronous, including mid-operation): outputs take the idle values above, plus rob_busy 0, rob_empty 1, dec_rob_id 0. All entries are invalidated and head = tail = 0.

Test Plan:
- Defaults (DEPTH 16, WB 2, COMMIT 2). Allocate pc 0x1000 with rd=1, writeback data 0xaaaa in cycle M -> commit_e_=2'b10, commit_pc=0x1000, commit_rd=1, commit_data=0xaaaa during M+2; then rob_empty=1.
- Allocate 8 entries (pc 0x2000..0x201c), write all back in random order on both ports -> commits in pc order, 2 per cycle once contiguous entries are done, never out of order; 8 total commits.
- Allocate 16 entries -> rob_busy=1 and a 17th dec_e_ is ignored. Write back id 0 -> busy clears the cycle after commit; the next allocation gets dec_rob_id=0 (wrap).
- Entry 0 done normal, entry 1 done with wb_miss_ and target 0x3000, entry 2 done -> slot 0 and slot 1 commit in the same cycle, flush_ low, flush_pc=0x3000; entry 2 never commits and rob_empty=1.
- Entry 0 with exception code 2, creg_tvec=0xcafe0000 -> commit_exp_ low, commit_exp_code=2, commit_we[0]=0, flush_pc=0xcafe0000. A same-cycle dec_e_ is dropped.
- Assert reset_ asynchronously (mid-clock) with 5 entries pending -> outputs take idle values immediately; afterwards dec_rob_id=0 and rob_empty=1.
